// File: rtl/control_unit_pkg.sv
// Shared encodings for the multi-cycle control unit: states, opcode/funct
// constants and the datapath mux/ALU select values.
package control_unit_pkg;

  localparam int unsigned WAIT_W = 3;

  typedef enum logic [3:0] {
    S_FETCH       = 4'd0,
    S_FETCH_WAIT  = 4'd1,
    S_DECODE      = 4'd2,
    S_EXEC_R      = 4'd3,
    S_EXEC_I      = 4'd4,
    S_ALU_WB      = 4'd5,
    S_MEM_ADDR    = 4'd6,
    S_MEM_RD      = 4'd7,
    S_MEM_RD_WAIT = 4'd8,
    S_MEM_WB      = 4'd9,
    S_MEM_WR      = 4'd10,
    S_BRANCH      = 4'd11,
    S_JUMP        = 4'd12
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_J     = 6'h02;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;

  typedef enum logic [2:0] {ALU_NOP = 3'b000, ALU_ADD = 3'b001, ALU_SUB = 3'b010, ALU_AND = 3'b011} alu_op_e;
  typedef enum logic [1:0] {SRCA_PC = 2'b00, SRCA_REG = 2'b01, SRCA_MDR = 2'b10} src_a_e;
  typedef enum logic [1:0] {SRCB_REG = 2'b00, SRCB_FOUR = 2'b01, SRCB_IMM = 2'b10, SRCB_IMM_SH2 = 2'b11} src_b_e;
  typedef enum logic [1:0] {PCS_ALU = 2'b00, PCS_ALUOUT = 2'b01, PCS_JUMP = 2'b10} pc_src_e;
  typedef enum logic [1:0] {CLS_R, CLS_I, CLS_LW, CLS_SW} instr_class_e;

  typedef struct packed {
    src_a_e  alu_src_a;
    src_b_e  alu_src_b;
    alu_op_e alu_op;
    pc_src_e pc_source;
    logic    pc_write;
    logic    pc_write_cond;
    logic    i_or_d;
    logic    mem_write;
    logic    ir_write;
    logic    reg_write;
    logic    reg_dst;
    logic    mem_to_reg;
  } ctrl_t;

  function automatic alu_op_e funct_to_alu(input logic [5:0] f);
    case (f)
      FN_ADD:  return ALU_ADD;
      FN_SUB:  return ALU_SUB;
      FN_AND:  return ALU_AND;
      default: return ALU_NOP;
    endcase
  endfunction

  function automatic instr_class_e opcode_class(input logic [5:0] op);
    case (op)
      OP_RTYPE: return CLS_R;
      OP_LW:    return CLS_LW;
      OP_SW:    return CLS_SW;
      default:  return CLS_I;
    endcase
  endfunction

  // Moore output table; fetch_ready is the "wait counter at zero" qualifier of FETCH_WAIT.
  function automatic ctrl_t ctrl_for_state(input state_e st, input logic fetch_ready,
                                           input logic is_rtype, input alu_op_e r_op);
    ctrl_t c;
    c = '0;
    case (st)
      S_FETCH: begin
        c.alu_src_b = SRCB_FOUR;
        c.alu_op    = ALU_ADD;
      end
      S_FETCH_WAIT: begin
        c.ir_write = fetch_ready;
        c.pc_write = fetch_ready;
      end
      S_DECODE: begin
        c.alu_src_b = SRCB_IMM_SH2;
        c.alu_op    = ALU_ADD;
      end
      S_EXEC_R: begin
        c.alu_src_a = SRCA_REG;
        c.alu_op    = r_op;
      end
      S_EXEC_I, S_MEM_ADDR: begin
        c.alu_src_a = SRCA_REG;
        c.alu_src_b = SRCB_IMM;
        c.alu_op    = ALU_ADD;
      end
      S_ALU_WB: begin
        c.reg_write = 1'b1;
        c.reg_dst   = is_rtype;
      end
      S_MEM_RD, S_MEM_RD_WAIT: c.i_or_d = 1'b1;
      S_MEM_WB: begin
        c.reg_write  = 1'b1;
        c.mem_to_reg = 1'b1;
      end
      S_MEM_WR: begin
        c.i_or_d    = 1'b1;
        c.mem_write = 1'b1;
      end
      S_BRANCH: begin
        c.alu_src_a     = SRCA_REG;
        c.alu_op        = ALU_SUB;
        c.pc_write_cond = 1'b1;
        c.pc_source     = PCS_ALUOUT;
      end
      S_JUMP: begin
        c.pc_write  = 1'b1;
        c.pc_source = PCS_JUMP;
      end
      default: ;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/control_unit_mem_wait_counter.sv
// Saturating down-counter that paces memory wait states; done_next
// reports whether the value after this edge will be zero.
module mem_wait_counter
  import control_unit_pkg::*;
#(
  parameter int unsigned MEM_LAT = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic dec,
  output logic done,
  output logic done_next
);

  localparam logic [WAIT_W-1:0] LOAD_VAL = WAIT_W'(MEM_LAT - 1);

  logic [WAIT_W-1:0] count;
  logic [WAIT_W-1:0] count_nxt;

  always_comb begin
    count_nxt = count;
    if (load)
      count_nxt = LOAD_VAL;
    else if (dec && count != '0)
      count_nxt = count - WAIT_W'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      count <= '0;
    else
      count <= count_nxt;
  end

  assign done      = (count == '0);
  assign done_next = (count_nxt == '0);

endmodule

// File: rtl/control_unit.sv
// Multi-cycle processor control FSM with registered Moore outputs and a
// registered one-cycle illegal-instruction pulse.
module control_unit
  import control_unit_pkg::*;
#(
  parameter int unsigned MEM_LAT = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ALUOp,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic       RegDst,
  output logic       MemToReg,
  output logic [1:0] PCSource,
  output logic       illegal,
  output logic [3:0] state
);

  state_e       state_q;
  state_e       state_nxt;
  ctrl_t        ctrl_q;
  instr_class_e cls_q;
  alu_op_e      r_op_q;
  alu_op_e      r_op_eff;
  logic         illegal_nxt;
  logic         wait_load;
  logic         wait_dec;
  logic         wait_done;
  logic         wait_done_next;

  // zero qualifies PCWriteCond in the datapath; the sequence never depends on it.
  logic unused_zero;
  assign unused_zero = zero;

  assign wait_load = (state_q == S_FETCH) || (state_q == S_MEM_RD);
  assign wait_dec  = (state_q == S_FETCH_WAIT) || (state_q == S_MEM_RD_WAIT);

  mem_wait_counter #(.MEM_LAT(MEM_LAT)) u_wait (
    .clk       (clk),
    .reset     (reset),
    .load      (wait_load),
    .dec       (wait_dec),
    .done      (wait_done),
    .done_next (wait_done_next)
  );

  // Outputs are registered from the next state, so EXEC_R's ALUOp must come from
  // the live funct on the DECODE edge, before the latched copy is available.
  assign r_op_eff = (state_q == S_DECODE) ? funct_to_alu(funct) : r_op_q;

  always_comb begin
    state_nxt   = state_q;
    illegal_nxt = 1'b0;
    case (state_q)
      S_FETCH:      state_nxt = S_FETCH_WAIT;
      S_FETCH_WAIT: if (wait_done) state_nxt = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_RTYPE:     state_nxt = S_EXEC_R;
          OP_ADDI:      state_nxt = S_EXEC_I;
          OP_LW, OP_SW: state_nxt = S_MEM_ADDR;
          OP_BEQ:       state_nxt = S_BRANCH;
          OP_J:         state_nxt = S_JUMP;
          default: begin
            state_nxt   = S_FETCH;
            illegal_nxt = 1'b1;
          end
        endcase
      end
      S_EXEC_R: begin
        if (r_op_q == ALU_NOP) begin
          state_nxt   = S_FETCH;
          illegal_nxt = 1'b1;
        end else begin
          state_nxt = S_ALU_WB;
        end
      end
      S_EXEC_I:      state_nxt = S_ALU_WB;
      S_MEM_ADDR:    state_nxt = (cls_q == CLS_SW) ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD:      state_nxt = S_MEM_RD_WAIT;
      // MEM_RD already spent one memory cycle, so leave as the count reaches zero.
      S_MEM_RD_WAIT: if (wait_done_next) state_nxt = S_MEM_WB;
      default:       state_nxt = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_FETCH;
      ctrl_q  <= ctrl_for_state(S_FETCH, 1'b0, 1'b0, ALU_NOP);
      illegal <= 1'b0;
      cls_q   <= CLS_R;
      r_op_q  <= ALU_NOP;
    end else begin
      state_q <= state_nxt;
      ctrl_q  <= ctrl_for_state(state_nxt, wait_done_next, cls_q == CLS_R, r_op_eff);
      illegal <= illegal_nxt;
      if (state_q == S_DECODE) begin
        cls_q  <= opcode_class(opcode);
        r_op_q <= funct_to_alu(funct);
      end
    end
  end

  assign ALUSrcA     = ctrl_q.alu_src_a;
  assign ALUSrcB     = ctrl_q.alu_src_b;
  assign ALUOp       = ctrl_q.alu_op;
  assign PCSource    = ctrl_q.pc_source;
  assign PCWrite     = ctrl_q.pc_write;
  assign PCWriteCond = ctrl_q.pc_write_cond;
  assign IorD        = ctrl_q.i_or_d;
  assign MemWrite    = ctrl_q.mem_write;
  assign IRWrite     = ctrl_q.ir_write;
  assign RegWrite    = ctrl_q.reg_write;
  assign RegDst      = ctrl_q.reg_dst;
  assign MemToReg    = ctrl_q.mem_to_reg;
  assign state       = state_q;

endmodule

// File: tb/tb_control_unit.sv
// Bench for control_unit: per-instruction expected cycle sequences checked
// every cycle on three instances (MEM_LAT = 1, 2, 3).
module tb_control_unit;
  import control_unit_pkg::*;

  // {ALUSrcA, ALUSrcB, ALUOp, PCSource, PCWrite, PCWriteCond, IorD, MemWrite,
  //  IRWrite, RegWrite, RegDst, MemToReg}
  localparam logic [16:0] FETCH_OUTS = {2'b00, 2'b01, 3'b001, 2'b00, 8'b0000_0000};

  typedef struct {
    logic [3:0]  st;
    logic [16:0] outs;
    logic        ill;
  } exp_t;

  logic        clk = 1'b0;
  logic [2:0]  rst_n;
  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic        zero;
  logic [16:0] obs       [3];
  logic [3:0]  obs_state [3];
  logic        obs_ill   [3];

  int   cur;
  bit   pend_illegal;
  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    logic [1:0] a, b, pcs;
    logic [2:0] op;
    logic       pw, pwc, iord, mw, irw, rw, rd, m2r, ill;
    logic [3:0] st;

    control_unit #(.MEM_LAT(g + 1)) dut (
      .clk(clk), .reset(rst_n[g]), .opcode(opcode), .funct(funct), .zero(zero),
      .ALUSrcA(a), .ALUSrcB(b), .ALUOp(op), .PCWrite(pw), .PCWriteCond(pwc),
      .IorD(iord), .MemWrite(mw), .IRWrite(irw), .RegWrite(rw), .RegDst(rd),
      .MemToReg(m2r), .PCSource(pcs), .illegal(ill), .state(st)
    );

    assign obs[g]       = {a, b, op, pcs, pw, pwc, iord, mw, irw, rw, rd, m2r};
    assign obs_state[g] = st;
    assign obs_ill[g]   = ill;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s (lat %0d, t=%0t): got %0h expected %0h", name, cur + 1, $time, act, exp);
    end
  endtask

  task automatic push(input state_e s, input logic [1:0] a, input logic [1:0] b,
                      input logic [2:0] op, input logic [1:0] pcs, input logic [7:0] stb);
    exp_t e;
    e.st   = 4'(s);
    e.outs = {a, b, op, pcs, stb};
    e.ill  = pend_illegal;
    pend_illegal = 1'b0;
    exp_q.push_back(e);
  endtask

  // Behavioural model: the cycle-by-cycle trace one instruction must produce.
  task automatic plan(input logic [5:0] op, input logic [5:0] fn, input int unsigned lat);
    logic [2:0]  r;
    int unsigned rd_wait;
    rd_wait = (lat > 1) ? lat - 1 : 1;
    push(S_FETCH, 2'b00, 2'b01, 3'b001, 2'b00, 8'b0000_0000);
    for (int unsigned i = 0; i < lat; i++)
      push(S_FETCH_WAIT, 2'b00, 2'b00, 3'b000, 2'b00, (i == lat - 1) ? 8'b1000_1000 : 8'b0000_0000);
    push(S_DECODE, 2'b00, 2'b11, 3'b001, 2'b00, 8'b0000_0000);
    case (op)
      6'h00: begin
        r = (fn == 6'h20) ? 3'b001 : (fn == 6'h22) ? 3'b010 : (fn == 6'h24) ? 3'b011 : 3'b000;
        push(S_EXEC_R, 2'b01, 2'b00, r, 2'b00, 8'b0000_0000);
        if (r == 3'b000) pend_illegal = 1'b1;
        else push(S_ALU_WB, 2'b00, 2'b00, 3'b000, 2'b00, 8'b0000_0110);
      end
      6'h08: begin
        push(S_EXEC_I, 2'b01, 2'b10, 3'b001, 2'b00, 8'b0000_0000);
        push(S_ALU_WB, 2'b00, 2'b00, 3'b000, 2'b00, 8'b0000_0100);
      end
      6'h23: begin
        push(S_MEM_ADDR, 2'b01, 2'b10, 3'b001, 2'b00, 8'b0000_0000);
        push(S_MEM_RD, 2'b00, 2'b00, 3'b000, 2'b00, 8'b0010_0000);
        for (int unsigned i = 0; i < rd_wait; i++)
          push(S_MEM_RD_WAIT, 2'b00, 2'b00, 3'b000, 2'b00, 8'b0010_0000);
        push(S_MEM_WB, 2'b00, 2'b00, 3'b000, 2'b00, 8'b0000_0101);
      end
      6'h2B: begin
        push(S_MEM_ADDR, 2'b01, 2'b10, 3'b001, 2'b00, 8'b0000_0000);
        push(S_MEM_WR, 2'b00, 2'b00, 3'b000, 2'b00, 8'b0011_0000);
      end
      6'h04: push(S_BRANCH, 2'b01, 2'b00, 3'b010, 2'b01, 8'b0100_0000);
      6'h02: push(S_JUMP, 2'b00, 2'b00, 3'b000, 2'b10, 8'b1000_0000);
      default: pend_illegal = 1'b1;
    endcase
  endtask

  // Called at posedge+2 of a FETCH cycle; ends at posedge+2 of the next FETCH.
  task automatic run(input logic [5:0] op, input logic [5:0] fn, input bit corrupt,
                     input logic [5:0] op2, input int unsigned exp_len);
    int unsigned lat, c;
    lat    = cur + 1;
    opcode = op;
    funct  = fn;
    plan(op, fn, lat);
    c = 0;
    do begin
      @(posedge clk); #2;
      c++;
      if (corrupt && c == lat + 2) opcode = op2;
    end while (obs_state[cur] != 4'(S_FETCH) && c < 30);
    chk("instr_cycles", c, exp_len);
    chk("model_drained", exp_q.size(), 0);
  endtask

  task automatic chk_reset_vals();
    chk("reset_state", obs_state[cur], 4'(S_FETCH));
    chk("reset_outs", obs[cur], FETCH_OUTS);
    chk("reset_illegal", obs_ill[cur], 1'b0);
  endtask

  initial begin : compare
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n[cur]) begin
        if (exp_q.size() == 0) begin
          chk("model_underflow", obs_state[cur], 4'hF);
        end else begin
          e = exp_q.pop_front();
          chk("state", obs_state[cur], e.st);
          chk("outputs", obs[cur], e.outs);
          chk("illegal", obs_ill[cur], e.ill);
        end
      end
    end
  end

  initial begin : stim
    opcode = '0; funct = '0; zero = 1'b0; rst_n = '0; cur = 1; pend_illegal = 1'b0;
    repeat (3) @(posedge clk);
    #2;

    // MEM_LAT = 2
    chk_reset_vals();
    rst_n[1] = 1'b1;
    run(6'h00, 6'h22, 1'b0, 6'h00, 6);
    run(6'h00, 6'h20, 1'b0, 6'h00, 6);
    run(6'h00, 6'h24, 1'b0, 6'h00, 6);
    run(6'h08, 6'h00, 1'b0, 6'h00, 6);
    run(6'h23, 6'h00, 1'b0, 6'h00, 8);
    run(6'h2B, 6'h00, 1'b0, 6'h00, 6);
    zero = 1'b0;
    run(6'h04, 6'h00, 1'b0, 6'h00, 5);
    zero = 1'b1;
    run(6'h04, 6'h00, 1'b0, 6'h00, 5);
    zero = 1'b0;
    run(6'h02, 6'h00, 1'b0, 6'h00, 5);
    run(6'h3F, 6'h00, 1'b0, 6'h00, 4);
    chk("illegal_pulse_op", obs_ill[cur], 1'b1);
    chk("illegal_no_write", obs[cur][7:0], 8'h00);
    run(6'h00, 6'h3F, 1'b0, 6'h00, 5);
    chk("illegal_pulse_funct", obs_ill[cur], 1'b1);
    run(6'h08, 6'h00, 1'b1, 6'h00, 6);
    run(6'h23, 6'h00, 1'b1, 6'h2B, 8);
    run(6'h02, 6'h00, 1'b0, 6'h00, 5);
    chk("illegal_cleared", obs_ill[cur], 1'b0);
    rst_n[1] = 1'b0;

    // MEM_LAT = 1
    cur = 0;
    chk_reset_vals();
    rst_n[0] = 1'b1;
    run(6'h2B, 6'h00, 1'b0, 6'h00, 5);
    run(6'h23, 6'h00, 1'b0, 6'h00, 7);
    run(6'h00, 6'h20, 1'b0, 6'h00, 5);
    run(6'h3F, 6'h00, 1'b0, 6'h00, 3);
    run(6'h02, 6'h00, 1'b0, 6'h00, 4);
    rst_n[0] = 1'b0;

    // MEM_LAT = 3, including reset in the middle of MEM_RD_WAIT
    cur = 2;
    chk_reset_vals();
    rst_n[2] = 1'b1;
    run(6'h04, 6'h00, 1'b0, 6'h00, 6);
    run(6'h23, 6'h00, 1'b0, 6'h00, 10);
    opcode = 6'h23;
    plan(6'h23, 6'h00, 3);
    repeat (7) begin
      @(posedge clk); #2;
    end
    chk("abort_pre_state", obs_state[cur], 4'(S_MEM_RD_WAIT));
    chk("abort_pre_iord", obs[cur][5], 1'b1);
    rst_n[2] = 1'b0;
    exp_q.delete();
    #1;
    chk("abort_state", obs_state[cur], 4'(S_FETCH));
    chk("abort_regwrite", obs[cur][2], 1'b0);
    chk("abort_memwrite", obs[cur][4], 1'b0);
    chk("abort_pcwrite", obs[cur][7], 1'b0);
    @(posedge clk); #2;
    chk_reset_vals();
    rst_n[2] = 1'b1;
    run(6'h00, 6'h20, 1'b0, 6'h00, 7);
    rst_n[2] = 1'b0;

    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
